// File: rtl/game_pkg.sv
// Shared types and constants for the air-hockey game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        GOAL   = 3'd3,
        OVER   = 3'd4,
        PAUSED = 3'd5
    } game_state_t;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    localparam int unsigned SCREEN_W = 1024;
    localparam int unsigned SCREEN_H = 768;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous push-button level, followed by a
// rising-edge detector that yields a one-cycle press pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= btn;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign press = sync_q & ~prev_q;

endmodule

// File: rtl/game_ctl.sv
// Frame-stepped air-hockey game sequencer: serve, play, goal, scoring and match end.
// Optional pause support is compiled in with GAME_CTL_PAUSE_EN.
module game_ctl
    import game_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 120,
    parameter int unsigned GOAL_FRAMES  = 60,
    parameter int unsigned GOAL_LEFT_X  = 12,
    parameter int unsigned GOAL_RIGHT_X = 1011,
    parameter int unsigned GOAL_Y_MIN   = 304,
    parameter int unsigned GOAL_Y_MAX   = 463
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic        pause,
    input  logic [11:0] ball_xpos,
    input  logic [11:0] ball_ypos,
    output logic        ball_en,
    output logic        ball_rst,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic [2:0]  state,
    output logic [1:0]  winner
);

    localparam logic [3:0]  WIN_LIM   = 4'(WIN_SCORE);
    localparam logic [7:0]  SERVE_LIM = 8'(SERVE_FRAMES);
    localparam logic [7:0]  GOAL_LIM  = 8'(GOAL_FRAMES);
    localparam logic [11:0] LEFT_X    = 12'(GOAL_LEFT_X);
    localparam logic [11:0] RIGHT_X   = 12'(GOAL_RIGHT_X);
    localparam logic [11:0] Y_MIN     = 12'(GOAL_Y_MIN);
    localparam logic [11:0] Y_MAX     = 12'(GOAL_Y_MAX);

    game_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [1:0]  winner_q, winner_d;
    logic        ball_en_q, ball_rst_q;
    logic        vblnk_q, tick_q;
    logic        start_press, pause_press;
    logic        in_window;

    btn_sync_edge u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (start),
        .press (start_press)
    );

    btn_sync_edge u_pause_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (pause),
        .press (pause_press)
    );

`ifndef GAME_CTL_PAUSE_EN
    logic unused_pause_press;
    assign unused_pause_press = pause_press;
`endif

    assign cnt_inc   = cnt_q + 8'd1;
    assign in_window = (ball_ypos >= Y_MIN) && (ball_ypos <= Y_MAX);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        winner_d = winner_q;
        unique case (state_q)
            IDLE, OVER: begin
                if (start_press) begin
                    state_d  = SERVE;
                    cnt_d    = 8'd0;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    winner_d = WINNER_NONE;
                end
            end
            SERVE: begin
                if (tick_q) begin
                    if (cnt_inc == SERVE_LIM) begin
                        state_d = PLAY;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            PLAY: begin
                // Left check has priority if the goal columns overlap.
                if (tick_q && in_window && (ball_xpos <= LEFT_X)) begin
                    state_d = GOAL;
                    cnt_d   = 8'd0;
                    if (p2_q != WIN_LIM) p2_d = p2_q + 4'd1;
                end else if (tick_q && in_window && (ball_xpos >= RIGHT_X)) begin
                    state_d = GOAL;
                    cnt_d   = 8'd0;
                    if (p1_q != WIN_LIM) p1_d = p1_q + 4'd1;
                end
`ifdef GAME_CTL_PAUSE_EN
                else if (pause_press) begin
                    state_d = PAUSED;
                end
`endif
            end
            GOAL: begin
                if (tick_q) begin
                    if (cnt_inc == GOAL_LIM) begin
                        cnt_d = 8'd0;
                        if (p1_q == WIN_LIM) begin
                            state_d  = OVER;
                            winner_d = WINNER_P1;
                        end else if (p2_q == WIN_LIM) begin
                            state_d  = OVER;
                            winner_d = WINNER_P2;
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            PAUSED: begin
`ifdef GAME_CTL_PAUSE_EN
                if (pause_press) state_d = PLAY;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            p1_q       <= 4'd0;
            p2_q       <= 4'd0;
            winner_q   <= WINNER_NONE;
            ball_en_q  <= 1'b0;
            ball_rst_q <= 1'b0;
            vblnk_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            winner_q   <= winner_d;
            ball_en_q  <= (state_d == PLAY);
            // Pulse on every entry into SERVE, aligned with the state change.
            ball_rst_q <= (state_d == SERVE) && (state_q != SERVE);
            vblnk_q    <= vblnk_in;
            tick_q     <= vblnk_in & ~vblnk_q;
        end
    end

    assign ball_en  = ball_en_q;
    assign ball_rst = ball_rst_q;
    assign score_p1 = p1_q;
    assign score_p2 = p2_q;
    assign state    = state_q;
    assign winner   = winner_q;

endmodule

// File: tb/tb_game_ctl.sv
// Self-checking bench for game_ctl: directed vector table, corner-case sequences and
// randomized frames checked against a frame-level model of the game rules.
module tb_game_ctl;
    import game_pkg::*;

    localparam int WIN    = 7;
    localparam int SERVEN = 120;
    localparam int GOALN  = 60;
    localparam int OP_START  = 0;
    localparam int OP_FRAMES = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vblnk_in;
    logic        start;
    logic        pause;
    logic [11:0] ball_xpos;
    logic [11:0] ball_ypos;
    logic        ball_en;
    logic        ball_rst;
    logic [3:0]  score_p1;
    logic [3:0]  score_p2;
    logic [2:0]  state;
    logic [1:0]  winner;

    int checks = 0;
    int errors = 0;
    int rst_seen = 0;

    // Frame-level reference model
    game_state_t m_state;
    int m_left, m_p1, m_p2, m_win, m_rst;

    typedef struct {
        int op; int n; int x; int y;
        int st; int p1; int p2; int win; int rst;
    } vec_t;
    vec_t vec[18];

    game_ctl #(
        .WIN_SCORE    (7),
        .SERVE_FRAMES (120),
        .GOAL_FRAMES  (60),
        .GOAL_LEFT_X  (12),
        .GOAL_RIGHT_X (1011),
        .GOAL_Y_MIN   (304),
        .GOAL_Y_MAX   (463)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vblnk_in  (vblnk_in),
        .start     (start),
        .pause     (pause),
        .ball_xpos (ball_xpos),
        .ball_ypos (ball_ypos),
        .ball_en   (ball_en),
        .ball_rst  (ball_rst),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .state     (state),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ball_rst) rst_seen <= rst_seen + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        chk({tag, " state"}, int'(state), int'(m_state));
        chk({tag, " ball_en"}, int'(ball_en), (m_state == PLAY) ? 1 : 0);
        chk({tag, " score_p1"}, int'(score_p1), m_p1);
        chk({tag, " score_p2"}, int'(score_p2), m_p2);
        chk({tag, " winner"}, int'(winner), m_win);
        chk({tag, " ball_rst pulses"}, rst_seen, m_rst);
    endtask

    task automatic model_start();
        if (m_state == IDLE || m_state == OVER) begin
            m_state = SERVE;
            m_left  = SERVEN;
            m_p1 = 0; m_p2 = 0; m_win = 0;
            m_rst++;
        end
    endtask

    task automatic model_frame(input int x, input int y);
        case (m_state)
            SERVE: begin
                m_left--;
                if (m_left == 0) m_state = PLAY;
            end
            PLAY: begin
                if (y >= 304 && y <= 463 && x <= 12) begin
                    m_p2 = (m_p2 < WIN) ? m_p2 + 1 : WIN;
                    m_state = GOAL; m_left = GOALN;
                end else if (y >= 304 && y <= 463 && x >= 1011) begin
                    m_p1 = (m_p1 < WIN) ? m_p1 + 1 : WIN;
                    m_state = GOAL; m_left = GOALN;
                end
            end
            GOAL: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_p1 == WIN) begin m_state = OVER; m_win = 1; end
                    else if (m_p2 == WIN) begin m_state = OVER; m_win = 2; end
                    else begin m_state = SERVE; m_left = SERVEN; m_rst++; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_pause();
`ifdef GAME_CTL_PAUSE_EN
        if (m_state == PLAY) m_state = PAUSED;
        else if (m_state == PAUSED) m_state = PLAY;
`endif
    endtask

    task automatic do_frame(input int x, input int y);
        @(posedge clk); #1;
        ball_xpos = 12'(x);
        ball_ypos = 12'(y);
        vblnk_in  = 1'b1;
        repeat (3) @(posedge clk);
        #1 vblnk_in = 1'b0;
        @(posedge clk); #1;
        model_frame(x, y);
    endtask

    task automatic do_frames(input int n, input int x, input int y);
        for (int i = 0; i < n; i++) do_frame(x, y);
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 model_start();
    endtask

    task automatic do_pause();
        @(posedge clk); #1 pause = 1'b1;
        repeat (4) @(posedge clk);
        #1 pause = 1'b0;
        repeat (4) @(posedge clk);
        #1 model_pause();
    endtask

    task automatic model_reset();
        m_state = IDLE; m_left = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
    endtask

    initial begin
        rst_n = 1'b0; vblnk_in = 1'b0; start = 1'b0; pause = 1'b0;
        ball_xpos = 12'd512; ball_ypos = 12'd384;
        model_reset();
        m_rst = 0;

        // op, n, x, y, state, p1, p2, winner, cumulative ball_rst pulses
        vec[0]  = '{OP_START,    0,  512, 384, int'(SERVE), 0, 0, 0, 1};
        vec[1]  = '{OP_FRAMES, 119,  512, 384, int'(SERVE), 0, 0, 0, 1};
        vec[2]  = '{OP_FRAMES,   1,  512, 384, int'(PLAY),  0, 0, 0, 1};
        vec[3]  = '{OP_FRAMES,   1, 1015, 300, int'(PLAY),  0, 0, 0, 1};
        vec[4]  = '{OP_FRAMES,   1, 1015, 464, int'(PLAY),  0, 0, 0, 1};
        vec[5]  = '{OP_FRAMES,   1,   11, 303, int'(PLAY),  0, 0, 0, 1};
        vec[6]  = '{OP_START,    0,  512, 384, int'(PLAY),  0, 0, 0, 1};
        vec[7]  = '{OP_FRAMES,   1,   10, 400, int'(GOAL),  0, 1, 0, 1};
        vec[8]  = '{OP_FRAMES,  59,   10, 400, int'(GOAL),  0, 1, 0, 1};
        vec[9]  = '{OP_FRAMES,   1,  512, 384, int'(SERVE), 0, 1, 0, 2};
        vec[10] = '{OP_FRAMES,   1,  512, 384, int'(SERVE), 0, 1, 0, 2};
        vec[11] = '{OP_START,    0,  512, 384, int'(SERVE), 0, 1, 0, 2};
        vec[12] = '{OP_FRAMES, 119,  512, 384, int'(PLAY),  0, 1, 0, 2};
        vec[13] = '{OP_FRAMES,   1, 1011, 463, int'(GOAL),  1, 1, 0, 2};
        vec[14] = '{OP_FRAMES,  60,  512, 384, int'(SERVE), 1, 1, 0, 3};
        vec[15] = '{OP_FRAMES, 120,   13, 400, int'(PLAY),  1, 1, 0, 3};
        vec[16] = '{OP_FRAMES,   1,   13, 400, int'(PLAY),  1, 1, 0, 3};
        vec[17] = '{OP_FRAMES,   1,   12, 463, int'(GOAL),  1, 2, 0, 3};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset state", int'(state), 0);
        chk("reset ball_en", int'(ball_en), 0);
        chk("reset ball_rst", int'(ball_rst), 0);
        chk("reset score_p1", int'(score_p1), 0);
        chk("reset score_p2", int'(score_p2), 0);
        chk("reset winner", int'(winner), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 18; i++) begin
            if (vec[i].op == OP_START) do_start();
            else do_frames(vec[i].n, vec[i].x, vec[i].y);
            @(negedge clk);
            chk($sformatf("vec%0d state", i), int'(state), vec[i].st);
            chk($sformatf("vec%0d ball_en", i), int'(ball_en),
                (vec[i].st == int'(PLAY)) ? 1 : 0);
            chk($sformatf("vec%0d score_p1", i), int'(score_p1), vec[i].p1);
            chk($sformatf("vec%0d score_p2", i), int'(score_p2), vec[i].p2);
            chk($sformatf("vec%0d winner", i), int'(winner), vec[i].win);
            chk($sformatf("vec%0d ball_rst pulses", i), rst_seen, vec[i].rst);
        end

        // P1 runs the score up to the win
        do_frames(GOALN, 512, 384);
        check_model("p1 run serve");
        for (int k = 0; k < 6; k++) begin
            do_frames(SERVEN, 512, 384);
            do_frame(1011, 304);
            check_model($sformatf("p1 goal %0d", k));
            do_frames(GOALN, 512, 384);
        end
        @(negedge clk);
        chk("match end state", int'(state), int'(OVER));
        chk("match end winner", int'(winner), 1);
        chk("match end score_p1", int'(score_p1), 7);
        chk("match end ball_en", int'(ball_en), 0);
        do_frames(5, 1011, 400);
        chk("over hold score_p1", int'(score_p1), 7);
        chk("over hold score_p2", int'(score_p2), 2);
        check_model("over hold");
        do_start();
        check_model("restart from over");
        chk("restart score_p1", int'(score_p1), 0);

        // Reset in the middle of a match
        do_frames(SERVEN, 512, 384);
        do_start();
        chk("start in play ignored", int'(state), int'(PLAY));
        do_frame(5, 350);
        do_frames(10, 512, 384);
        check_model("pre-reset goal");
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("async reset state", int'(state), 0);
        chk("async reset score_p2", int'(score_p2), 0);
        chk("async reset ball_en", int'(ball_en), 0);
        chk("async reset ball_rst", int'(ball_rst), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        check_model("after reset");

        // Pause behaviour
        do_start();
        do_frames(SERVEN, 512, 384);
        do_pause();
        @(negedge clk);
`ifdef GAME_CTL_PAUSE_EN
        chk("paused state", int'(state), int'(PAUSED));
        chk("paused ball_en", int'(ball_en), 0);
        do_frames(3, 10, 400);
        @(negedge clk);
        chk("paused no score", int'(score_p2), 0);
        chk("paused still", int'(state), int'(PAUSED));
        do_pause();
        @(negedge clk);
        chk("unpause state", int'(state), int'(PLAY));
`else
        chk("pause ignored state", int'(state), int'(PLAY));
        chk("pause ignored ball_en", int'(ball_en), 1);
`endif
        check_model("pause seq");

        // Randomized frames against the model
        for (int n = 0; n < 3000; n++) begin
            int r, x, y;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                do_start();
            end else if (r < 6) begin
                do_pause();
            end else begin
                case ($urandom_range(0, 2))
                    0: x = int'($urandom_range(0, 1023));
                    1: x = int'($urandom_range(0, 16));
                    default: x = int'($urandom_range(1006, 1023));
                endcase
                y = int'($urandom_range(290, 480));
                do_frame(x, y);
            end
            check_model($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
